// File: rtl/ysyx_220053_mem_pkg.sv
// Shared definitions for the IFU/LSU main-memory arbiter.
//   state_e         : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   REQ_IFU/REQ_LSU : requester ids used for grant bookkeeping
//   DEF_AW/DEF_DW   : default address and data widths
package ysyx_220053_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  localparam int DEF_AW = 64;
  localparam int DEF_DW = 64;

endpackage

// File: rtl/ysyx_220053_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   req        in  [1:0] : request bits, bit 0 = IFU, bit 1 = LSU
//   last_grant in        : id of the requester served most recently
//   gnt        out [1:0] : one-hot grant (all zero when nothing requests)
module ysyx_220053_rr_arb2
  import ysyx_220053_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[0] && req[1]) begin
      // On a tie the side that was not served last wins.
      gnt = (last_grant == REQ_LSU) ? 2'b01 : 2'b10;
    end else if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/ysyx_220053_mem_arbiter.sv
// Shares the single main-memory port between the IFU (requester 0) and the
// LSU (requester 1). One transaction is outstanding at a time; requests are
// latched on the request handshake, issued to memory, the response is
// latched and then returned to the granted requester.
// Ports:
//   clk, rst (async, active-low)
//   ifu_req_*  / ifu_resp_*  : IFU read-only request and response channels
//   lsu_req_*  / lsu_resp_*  : LSU read/write request and response channels
//   mem_req_*                : memory request channel (valid/ready)
//   mem_resp_*               : memory response (always accepted)
module ysyx_220053_mem_arbiter
  import ysyx_220053_mem_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_req_addr,
  output logic            ifu_resp_valid,
  input  logic            ifu_resp_ready,
  output logic [DW-1:0]   ifu_resp_rdata,

  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_req_addr,
  input  logic            lsu_req_wen,
  input  logic [DW-1:0]   lsu_req_wdata,
  input  logic [DW/8-1:0] lsu_req_wmask,
  output logic            lsu_resp_valid,
  input  logic            lsu_resp_ready,
  output logic [DW-1:0]   lsu_resp_rdata,

  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_req_addr,
  output logic            mem_req_wen,
  output logic [DW-1:0]   mem_req_wdata,
  output logic [DW/8-1:0] mem_req_wmask,
  input  logic            mem_resp_valid,
  input  logic [DW-1:0]   mem_resp_rdata
);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              gid_q, gid_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW/8-1:0]   wmask_q, wmask_d;
  logic [DW-1:0]     rdata_q, rdata_d;

  logic [1:0]        gnt;
  logic              idle;
  logic              resp_ready_sel;

  ysyx_220053_rr_arb2 u_arb (
    .req        ({lsu_req_valid, ifu_req_valid}),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  assign idle = (state_q == IDLE);

  // Readies are gated by rst so they drop in the same cycle reset asserts,
  // even though the registered state already reads IDLE.
  assign ifu_req_ready = rst & idle & gnt[0];
  assign lsu_req_ready = rst & idle & gnt[1];

  assign resp_ready_sel = (gid_q == REQ_IFU) ? ifu_resp_ready : lsu_resp_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gid_d        = gid_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt[0]) begin
          // IFU is read-only: force a clean read request.
          gid_d   = REQ_IFU;
          addr_d  = ifu_req_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          state_d = ISSUE;
        end else if (gnt[1]) begin
          gid_d   = REQ_LSU;
          addr_d  = lsu_req_addr;
          wen_d   = lsu_req_wen;
          wdata_d = lsu_req_wdata;
          wmask_d = lsu_req_wmask;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Writes also complete on mem_resp_valid; the data is simply unused.
        if (mem_resp_valid) begin
          rdata_d = mem_resp_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready_sel) begin
          last_grant_d = gid_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_LSU;
      gid_q        <= REQ_IFU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gid_q        <= gid_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      rdata_q      <= rdata_d;
    end
  end

  assign mem_req_valid  = (state_q == ISSUE);
  assign mem_req_addr   = addr_q;
  assign mem_req_wen    = wen_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wmask  = wmask_q;

  assign ifu_resp_valid = (state_q == RESP) && (gid_q == REQ_IFU);
  assign lsu_resp_valid = (state_q == RESP) && (gid_q == REQ_LSU);
  assign ifu_resp_rdata = rdata_q;
  assign lsu_resp_rdata = rdata_q;

endmodule

// File: tb/tb_ysyx_220053_mem_arbiter.sv
module tb_ysyx_220053_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [63:0] ifu_req_addr;
  logic        ifu_resp_valid, ifu_resp_ready;
  logic [63:0] ifu_resp_rdata;
  logic        lsu_req_valid, lsu_req_ready;
  logic [63:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [63:0] lsu_req_wdata;
  logic [7:0]  lsu_req_wmask;
  logic        lsu_resp_valid, lsu_resp_ready;
  logic [63:0] lsu_resp_rdata;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;

  int n_chk;
  int n_fail;

  ysyx_220053_mem_arbiter #(.AW(64), .DW(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_req_addr   (ifu_req_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_ready (ifu_resp_ready),
    .ifu_resp_rdata (ifu_resp_rdata),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_req_addr   (lsu_req_addr),
    .lsu_req_wen    (lsu_req_wen),
    .lsu_req_wdata  (lsu_req_wdata),
    .lsu_req_wmask  (lsu_req_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_ready (lsu_resp_ready),
    .lsu_resp_rdata (lsu_resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wen    (mem_req_wen),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected to have finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_req_valid  = 1'b0;
    ifu_req_addr   = '0;
    ifu_resp_ready = 1'b0;
    lsu_req_valid  = 1'b0;
    lsu_req_addr   = '0;
    lsu_req_wen    = 1'b0;
    lsu_req_wdata  = '0;
    lsu_req_wmask  = '0;
    lsu_resp_ready = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
  endtask

  // Leaves the bench 1 time unit after a rising edge with the DUT in IDLE.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Zero-wait memory: call in the handshake cycle; returns in the RESP cycle.
  task automatic serve(input logic [63:0] rd);
    step();
    step();
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rd;
    step();
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    step();
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    mem_req_ready = 1'b1;
    #1;
    n_chk++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_readies: got %b want 00", {ifu_req_ready, lsu_req_ready});
    end
    n_chk++;
    if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_valids: got %b want 000", {mem_req_valid, ifu_resp_valid, lsu_resp_valid});
    end
    n_chk++;
    if (mem_req_addr !== 64'h0 || mem_req_wdata !== 64'h0 || mem_req_wmask !== 8'h0 || ifu_resp_rdata !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: got addr %h wdata %h wmask %h rdata %h want all 0", mem_req_addr, mem_req_wdata, mem_req_wmask, ifu_resp_rdata);
    end
    clear_inputs();
  endtask

  task automatic test_ifu_read();
    do_reset();
    mem_req_ready  = 1'b1;
    ifu_resp_ready = 1'b1;
    ifu_req_valid  = 1'b1;
    ifu_req_addr   = 64'h0000_0000_8000_0000;
    #1;
    n_chk++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL ifu_read_c0_ready: got %b want 10", {ifu_req_ready, lsu_req_ready});
    end
    step(); // cycle 1
    ifu_req_valid = 1'b0;
    ifu_req_addr  = 64'h1234;
    #1;
    n_chk++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0000 || mem_req_wen !== 1'b0 || mem_req_wmask !== 8'h00) begin
      n_fail++; $display("FAIL ifu_read_c1_mem: got v %b addr %h wen %b wmask %h want v 1 addr 80000000 wen 0 wmask 00", mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask);
    end
    step(); // cycle 2
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h0000_0013_0000_0093;
    #1;
    n_chk++;
    if (mem_req_valid !== 1'b0 || ifu_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL ifu_read_c2: got mem_v %b resp_v %b want 0 0", mem_req_valid, ifu_resp_valid);
    end
    step(); // cycle 3
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 64'hFFFF;
    #1;
    n_chk++;
    if (ifu_resp_valid !== 1'b1 || ifu_resp_rdata !== 64'h0000_0013_0000_0093 || lsu_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL ifu_read_c3_resp: got v %b rdata %h lsu_v %b want 1 0000001300000093 0", ifu_resp_valid, ifu_resp_rdata, lsu_resp_valid);
    end
    step(); // cycle 4: back in IDLE
    ifu_req_valid = 1'b1;
    #1;
    n_chk++;
    if (ifu_resp_valid !== 1'b0 || ifu_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ifu_read_c4_idle: got resp_v %b req_ready %b want 0 1", ifu_resp_valid, ifu_req_ready);
    end
    ifu_req_valid = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    mem_req_ready  = 1'b1;
    ifu_resp_ready = 1'b1;
    lsu_resp_ready = 1'b1;
    ifu_req_valid  = 1'b1;
    ifu_req_addr   = 64'h8000_0000;
    lsu_req_valid  = 1'b1;
    lsu_req_addr   = 64'h8000_0100;
    #1;
    n_chk++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL rr_first_grant: got %b want 10", {ifu_req_ready, lsu_req_ready});
    end
    serve(64'h1111_1111_1111_1111);
    n_chk++;
    if (ifu_resp_valid !== 1'b1 || lsu_resp_valid !== 1'b0 || lsu_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL rr_first_resp: got ifu_v %b lsu_v %b lsu_rdy %b want 1 0 0", ifu_resp_valid, lsu_resp_valid, lsu_req_ready);
    end
    step();
    n_chk++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL rr_second_grant: got %b want 01", {ifu_req_ready, lsu_req_ready});
    end
    serve(64'h2222_3333_4444_5555);
    n_chk++;
    if (lsu_resp_valid !== 1'b1 || ifu_resp_valid !== 1'b0 || lsu_resp_rdata !== 64'h2222_3333_4444_5555) begin
      n_fail++; $display("FAIL rr_second_resp: got lsu_v %b ifu_v %b rdata %h want 1 0 2222333344445555", lsu_resp_valid, ifu_resp_valid, lsu_resp_rdata);
    end
    step();
    n_chk++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL rr_third_grant: got %b want 10", {ifu_req_ready, lsu_req_ready});
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
  endtask

  task automatic test_lsu_write();
    do_reset();
    mem_req_ready  = 1'b1;
    ifu_resp_ready = 1'b1;
    lsu_resp_ready = 1'b1;
    lsu_req_valid  = 1'b1;
    lsu_req_addr   = 64'h8000_1000;
    lsu_req_wen    = 1'b1;
    lsu_req_wdata  = 64'hDEAD_BEEF_CAFE_F00D;
    lsu_req_wmask  = 8'h0F;
    #1;
    n_chk++;
    if (lsu_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL wr_grant: got %b want 1", lsu_req_ready);
    end
    step(); // cycle 1: scramble LSU fields, IFU starts waiting
    lsu_req_valid = 1'b0;
    lsu_req_addr  = '0;
    lsu_req_wen   = 1'b0;
    lsu_req_wdata = '0;
    lsu_req_wmask = 8'hFF;
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 64'h8000_0004;
    #1;
    n_chk++;
    if (mem_req_valid !== 1'b1 || mem_req_wen !== 1'b1 || mem_req_addr !== 64'h8000_1000 || mem_req_wdata !== 64'hDEAD_BEEF_CAFE_F00D || mem_req_wmask !== 8'h0F) begin
      n_fail++; $display("FAIL wr_mem_fields: got v %b wen %b addr %h wdata %h wmask %h want 1 1 80001000 deadbeefcafef00d 0f", mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask);
    end
    n_chk++;
    if (ifu_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL wr_ifu_blocked: got %b want 0", ifu_req_ready);
    end
    step(); // cycle 2: write ack
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h0;
    step(); // cycle 3
    mem_resp_valid = 1'b0;
    n_chk++;
    if (lsu_resp_valid !== 1'b1 || ifu_resp_valid !== 1'b0 || ifu_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL wr_resp: got lsu_v %b ifu_v %b ifu_rdy %b want 1 0 0", lsu_resp_valid, ifu_resp_valid, ifu_req_ready);
    end
    step(); // cycle 4: IFU finally granted
    n_chk++;
    if (ifu_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL wr_ifu_after: got %b want 1", ifu_req_ready);
    end
    step(); // cycle 5: IFU issue
    ifu_req_valid = 1'b0;
    #1;
    n_chk++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0004 || mem_req_wen !== 1'b0 || mem_req_wmask !== 8'h00 || mem_req_wdata !== 64'h0) begin
      n_fail++; $display("FAIL wr_ifu_issue: got v %b addr %h wen %b wmask %h wdata %h want 1 80000004 0 00 0", mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask, mem_req_wdata);
    end
  endtask

  task automatic test_backpressure();
    int resp_cnt;
    do_reset();
    ifu_resp_ready = 1'b1;
    mem_req_ready  = 1'b0;
    ifu_req_valid  = 1'b1;
    ifu_req_addr   = 64'h8000_2000;
    step(); // cycle 1
    ifu_req_valid = 1'b0;
    ifu_req_addr  = 64'h0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_2000 || mem_req_wen !== 1'b0) begin
        n_fail++; $display("FAIL bp_issue_hold%0d: got v %b addr %h wen %b want 1 80002000 0", i, mem_req_valid, mem_req_addr, mem_req_wen);
      end
      step();
    end
    mem_req_ready = 1'b1;
    #1;
    n_chk++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_2000) begin
      n_fail++; $display("FAIL bp_issue_accept: got v %b addr %h want 1 80002000", mem_req_valid, mem_req_addr);
    end
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (mem_req_valid !== 1'b0 || ifu_resp_valid !== 1'b0 || mem_req_addr !== 64'h8000_2000) begin
        n_fail++; $display("FAIL bp_wait%0d: got mem_v %b resp_v %b addr %h want 0 0 80002000", i, mem_req_valid, ifu_resp_valid, mem_req_addr);
      end
      step();
    end
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h0123_4567_89AB_CDEF;
    step();
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 64'h0;
    resp_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (ifu_resp_valid === 1'b1) begin
        resp_cnt++;
        n_chk++;
        if (ifu_resp_rdata !== 64'h0123_4567_89AB_CDEF) begin
          n_fail++; $display("FAIL bp_rdata: got %h want 0123456789abcdef", ifu_resp_rdata);
        end
      end
      step();
    end
    n_chk++;
    if (resp_cnt !== 1) begin
      n_fail++; $display("FAIL bp_resp_count: got %0d want 1", resp_cnt);
    end
  endtask

  task automatic test_resp_stall();
    do_reset();
    mem_req_ready  = 1'b1;
    ifu_resp_ready = 1'b0;
    lsu_resp_ready = 1'b1;
    ifu_req_valid  = 1'b1;
    ifu_req_addr   = 64'h8000_3000;
    lsu_req_valid  = 1'b1;
    lsu_req_addr   = 64'h8000_4000;
    serve(64'hA5A5_5A5A_0F0F_F0F0);
    ifu_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (ifu_resp_valid !== 1'b1 || ifu_resp_rdata !== 64'hA5A5_5A5A_0F0F_F0F0 || lsu_req_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold%0d: got v %b rdata %h lsu_rdy %b want 1 a5a55a5a0f0ff0f0 0", i, ifu_resp_valid, ifu_resp_rdata, lsu_req_ready);
      end
      step();
    end
    ifu_resp_ready = 1'b1;
    #1;
    n_chk++;
    if (ifu_resp_valid !== 1'b1 || lsu_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: got v %b lsu_rdy %b want 1 0", ifu_resp_valid, lsu_req_ready);
    end
    step();
    n_chk++;
    if (ifu_resp_valid !== 1'b0 || lsu_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_next_grant: got ifu_v %b lsu_rdy %b want 0 1", ifu_resp_valid, lsu_req_ready);
    end
    lsu_req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_req_ready  = 1'b1;
    ifu_resp_ready = 1'b1;
    ifu_req_valid  = 1'b1;
    ifu_req_addr   = 64'h8000_5000;
    serve(64'h5555); // leaves last_grant = IFU once RESP completes
    step();          // IDLE, IFU granted again
    step();          // ISSUE
    step();          // WAIT
    n_chk++;
    if (mem_req_valid !== 1'b0 || ifu_resp_valid !== 1'b0 || ifu_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_in_wait: got mem_v %b resp_v %b rdy %b want 0 0 0", mem_req_valid, ifu_resp_valid, ifu_req_ready);
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready} !== 5'b0 || mem_req_addr !== 64'h0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %b addr %h want 00000 0", {mem_req_valid, ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready}, mem_req_addr);
    end
    step();
    step();
    rst = 1'b1;
    ifu_req_valid  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'hDEAD;
    step();
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
        n_fail++; $display("FAIL mid_stray%0d: got ifu_v %b lsu_v %b mem_v %b want 0 0 0", i, ifu_resp_valid, lsu_resp_valid, mem_req_valid);
      end
      step();
    end
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    #1;
    n_chk++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL mid_fresh_grant: got %b want 10", {ifu_req_ready, lsu_req_ready});
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    clear_inputs();
    test_reset();
    test_ifu_read();
    test_round_robin();
    test_lsu_write();
    test_backpressure();
    test_resp_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
